// File: rtl/a2d_spi_resp.sv
// SPI responder modelling an 8-channel 12-bit SAR ADC: frame N selects a channel, frame N+1 returns it.
// Optional `A2D_RESP_ERRCNT_EN adds a saturating malformed-frame counter on err_cnt.
module a2d_spi_resp #(
    parameter int NUM_CH = 8,
    parameter int RES_W  = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    SS_n,
    input  logic                    SCLK,
    input  logic                    MOSI,
    output logic                    MISO,
    input  logic [NUM_CH*RES_W-1:0] ch_val,
    output logic [2:0]              chnnl_dec,
    output logic                    frm_done
`ifdef A2D_RESP_ERRCNT_EN
    ,
    output logic [7:0]              err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t             state, nxt_state;
    logic [2:0]         ss_sy, sclk_sy;
    logic [1:0]         mosi_sy;
    logic [15:0]        tx_sr, rx_sr;
    logic [4:0]         bit_cnt;
    logic [RES_W-1:0]   resp, sel_val;
    logic               ss_s, mosi_s, sclk_rise, sclk_fall;
    logic               unused_bits;

    // Bits [0] are the async capture flops; [2] only feeds edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_sy   <= 3'b111;
            sclk_sy <= 3'b000;
            mosi_sy <= 2'b00;
        end else begin
            ss_sy   <= {ss_sy[1:0], SS_n};
            sclk_sy <= {sclk_sy[1:0], SCLK};
            mosi_sy <= {mosi_sy[0], MOSI};
        end
    end

    assign ss_s      = ss_sy[1];
    assign mosi_s    = mosi_sy[1];
    assign sclk_rise = sclk_sy[1] & ~sclk_sy[2];
    assign sclk_fall = ~sclk_sy[1] & sclk_sy[2];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    // IDLE tests the SS_n level, so a fall that lands during DONE is not lost.
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (!ss_s) nxt_state = LOAD;
            LOAD:    nxt_state = SHIFT;
            SHIFT:   if (ss_s) nxt_state = DONE;
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        sel_val = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (rx_sr[13:11] == 3'(k)) sel_val = ch_val[k*RES_W +: RES_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            resp      <= '0;
            chnnl_dec <= '0;
            frm_done  <= 1'b0;
`ifdef A2D_RESP_ERRCNT_EN
            err_cnt   <= '0;
`endif
        end else begin
            frm_done <= 1'b0;
            case (state)
                LOAD: begin
                    tx_sr   <= {{(16-RES_W){1'b0}}, resp};
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_sr <= {rx_sr[14:0], mosi_s};
                        if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
                    end
                    if (sclk_fall) tx_sr <= {tx_sr[14:0], 1'b0};
                end
                DONE: begin
                    if (bit_cnt == 5'd16) begin
                        chnnl_dec <= rx_sr[13:11];
                        resp      <= sel_val;
                        frm_done  <= 1'b1;
                    end
`ifdef A2D_RESP_ERRCNT_EN
                    else if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign MISO = (state == LOAD || state == SHIFT) ? tx_sr[15] : 1'b0;

    // Command bits outside the channel field carry no meaning.
    assign unused_bits = ^{rx_sr[15:14], rx_sr[10:0]};

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: directed and random two-frame reads against a frame-level reference model.
module tb_a2d_spi_resp;

    logic        clk = 1'b0;
    logic        rst_n, SS_n, SCLK, MOSI;
    logic        MISO;
    logic [95:0] ch_val;
    logic [2:0]  chnnl_dec;
    logic        frm_done;
`ifdef A2D_RESP_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    a2d_spi_resp dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .ch_val(ch_val), .chnnl_dec(chnnl_dec), .frm_done(frm_done)
`ifdef A2D_RESP_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    int frm_cnt = 0, wide_cnt = 0;
    logic prev_done = 1'b0;

    // Reference model: what the responder remembers between frames.
    logic [11:0] m_resp = '0;
    logic [2:0]  m_ch   = '0;
    int          m_err  = 0;

    always @(negedge clk) begin
        if (frm_done) frm_cnt++;
        if (frm_done && prev_done) wide_cnt++;
        prev_done = frm_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [11:0] v);
        ch_val[k*12 +: 12] = v;
    endtask

    // Mode-0 master, SCLK = clk/8; all edges land on clk negedges.
    task automatic do_frame(input logic [15:0] cmd, input int nbits, output logic [15:0] rx);
        rx = '0;
        SS_n = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            #40 SCLK = 1'b1;
            rx = {rx[14:0], MISO};
            #40 SCLK = 1'b0;
        end
        #40 SS_n = 1'b1;
        MOSI = 1'b0;
        #100;
    endtask

    task automatic run_frame(input string tag, input logic [15:0] cmd, input int nbits);
        logic [15:0] rx;
        int          f0;
        f0 = frm_cnt;
        do_frame(cmd, nbits, rx);
        if (nbits == 16) begin
            chk({tag, "_rx"}, 32'(rx), 32'({4'h0, m_resp}));
            m_resp = ch_val[cmd[13:11]*12 +: 12];
            m_ch   = cmd[13:11];
            chk({tag, "_pulse"}, 32'(frm_cnt - f0), 32'd1);
        end else begin
            if (m_err < 255) m_err++;
            chk({tag, "_pulse"}, 32'(frm_cnt - f0), 32'd0);
        end
        chk({tag, "_ch"}, 32'(chnnl_dec), 32'(m_ch));
`ifdef A2D_RESP_ERRCNT_EN
        chk({tag, "_err"}, 32'(err_cnt), 32'(m_err));
`endif
    endtask

    function automatic logic [15:0] mk_cmd(input int ch);
        logic [15:0] c;
        c = 16'($urandom);
        c[13:11] = 3'(ch);
        return c;
    endfunction

    initial begin
        rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0; ch_val = '0;
        @(negedge clk);
        #50;
        chk("rst_miso", 32'(MISO), 32'd0);
        chk("rst_ch", 32'(chnnl_dec), 32'd0);
        chk("rst_done", 32'(frm_done), 32'd0);
        rst_n = 1'b1;
        #50;

        // Two-frame read of channel 2; first frame after reset returns zeros.
        set_ch(2, 12'hA5C);
        run_frame("rd2_f1", 16'h1000, 16);
        run_frame("rd2_f2", 16'h0000, 16);

        // Channel sweep, ignored command bits randomized.
        for (int k = 0; k < 8; k++) set_ch(k, 12'(12'h101 * k));
        for (int k = 0; k < 8; k++) run_frame($sformatf("sweep%0d", k), mk_cmd(k), 16);
        chk("sweep_ch7", 32'(chnnl_dec), 32'd7);
        run_frame("sweep_tail", mk_cmd(3), 16);

        // Malformed frames: too short and too long.
        run_frame("short10", mk_cmd(6), 10);
        run_frame("long17", mk_cmd(1), 17);
        run_frame("after_bad", mk_cmd(4), 16);

        // ch_val change after the command frame does not affect the loaded response.
        set_ch(4, 12'h123);
        run_frame("chg_cmd", mk_cmd(4), 16);
        set_ch(4, 12'h456);
        run_frame("chg_rsp", mk_cmd(0), 16);

        // Random traffic, including occasional bad frame lengths.
        for (int n = 0; n < 24; n++) begin
            int nb;
            set_ch($urandom_range(0, 7), 12'($urandom));
            nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 17) : 16;
            run_frame($sformatf("rnd%0d", n), mk_cmd($urandom_range(0, 7)), nb);
        end

        // Reset at bit 8 of a frame whose response MSB region is nonzero.
        set_ch(7, 12'hFFF);
        run_frame("pre_rst", mk_cmd(7), 16);
        SS_n = 1'b0;
        #100;
        for (int i = 0; i < 8; i++) begin
            MOSI = 1'b1;
            #40 SCLK = 1'b1;
            #40 SCLK = 1'b0;
        end
        #40;
        rst_n = 1'b0;
        #10;
        chk("mid_rst_miso", 32'(MISO), 32'd0);
        SS_n = 1'b1; MOSI = 1'b0;
        #50;
        chk("mid_rst_done", 32'(frm_done), 32'd0);
        chk("mid_rst_ch", 32'(chnnl_dec), 32'd0);
        rst_n = 1'b1;
        m_resp = '0; m_ch = '0; m_err = 0;
        #50;
        set_ch(5, 12'h5E7);
        run_frame("post_rst_f1", mk_cmd(5), 16);
        run_frame("post_rst_f2", mk_cmd(5), 16);

        chk("done_width", 32'(wide_cnt), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
